// File: rtl/fft_out_serializer.sv
// fft_out_serializer
// Captures one parallel 8-point FFT result frame and streams it out one
// complex sample per transfer, bins 0..7 in order, over a valid/ready
// handshake. Two frame buffers (ping-pong) let a new frame arrive while
// the previous one drains.
// Optional build macro: FFT_SER_SCALE_EN -- when defined, outputs are the
// stored words arithmetically shifted right by 3 (divide-by-8 FFT gain).
module fft_out_serializer #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**N-1:0]   y0,
  input  logic [2**N-1:0]   y4,
  input  logic [2**N-1:0]   yr1,
  input  logic [2**N-1:0]   yi1,
  input  logic [2**N-1:0]   yr2,
  input  logic [2**N-1:0]   yi2,
  input  logic [2**N-1:0]   yr3,
  input  logic [2**N-1:0]   yi3,
  input  logic [2**N-1:0]   yr5,
  input  logic [2**N-1:0]   yi5,
  input  logic [2**N-1:0]   yr6,
  input  logic [2**N-1:0]   yi6,
  input  logic [2**N-1:0]   yr7,
  input  logic [2**N-1:0]   yi7,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**N-1:0]   out_re,
  output logic [2**N-1:0]   out_im,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              ovf
);

  localparam int W = 2**N;
  localparam logic [W-1:0] ZERO = '0;

  // Occupancy doubles as the state: number of full buffers.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [W-1:0] buf_re [2][8];
  logic [W-1:0] buf_im [2][8];
  logic [W-1:0] frame_re [8];
  logic [W-1:0] frame_im [8];

  logic       wp;
  logic       rp;
  logic [1:0] cnt;
  logic [2:0] idx;

  logic       capture;
  logic       xfer;
  logic       final_xfer;
  logic [W-1:0] sel_re;
  logic [W-1:0] sel_im;

  // Real-only bins 0 and 4 carry a constant zero imaginary part, so those
  // two storage words are constant and fold away.
  assign frame_re = '{y0,   yr1, yr2, yr3, y4,   yr5, yr6, yr7};
  assign frame_im = '{ZERO, yi1, yi2, yi3, ZERO, yi5, yi6, yi7};

  assign in_ready   = (cnt != TWO);
  assign out_valid  = (cnt != EMPTY);
  assign capture    = in_valid && in_ready;
  assign xfer       = out_valid && out_ready;
  assign final_xfer = xfer && (idx == 3'd7);

  // Buffer writes, pointers, read index, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see pre-edge values.
    if (rst) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= EMPTY;
      idx <= 3'd0;
      ovf <= 1'b0;
      // NOTE: the frame storage is cleared too, so outputs read 0 out of reset.
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 8; k++) begin
          buf_re[b][k] <= ZERO;
          buf_im[b][k] <= ZERO;
        end
      end
    end else begin
      if (capture) begin
        for (int k = 0; k < 8; k++) begin
          buf_re[wp][k] <= frame_re[k];
          buf_im[wp][k] <= frame_im[k];
        end
        wp <= ~wp;
      end

      if (in_valid && !in_ready) begin
        ovf <= 1'b1;
      end

      if (xfer) begin
        idx <= idx + 3'd1;
        if (idx == 3'd7) begin
          rp <= ~rp;
        end
      end

      case (cnt)
        EMPTY: if (capture) cnt <= ONE;
        ONE: begin
          if (capture && !final_xfer)      cnt <= TWO;
          else if (final_xfer && !capture) cnt <= EMPTY;
        end
        TWO:     if (final_xfer) cnt <= ONE;
        default: cnt <= EMPTY;
      endcase
    end
  end

  // Output words come straight from registered state, never from inputs.
  assign sel_re = buf_re[rp][idx];
  assign sel_im = buf_im[rp][idx];

`ifdef FFT_SER_SCALE_EN
  assign out_re = $signed(sel_re) >>> 3;
  assign out_im = $signed(sel_im) >>> 3;
`else
  assign out_re = sel_re;
  assign out_im = sel_im;
`endif

  assign out_idx  = idx;
  assign out_last = (idx == 3'd7);

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer
// Directed bench for fft_out_serializer (N = 4, 16-bit words). A queue of
// whole frames models the buffers; one compare process checks the DUT
// against it on every falling edge. Literal checks pin the model.
// Honours FFT_SER_SCALE_EN the same way the design does.
module tb_fft_out_serializer;

  typedef struct packed {
    logic [7:0][15:0] re;
    logic [7:0][15:0] im;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y0, y4, yr1, yi1, yr2, yi2, yr3, yi3;
  logic [15:0] yr5, yi5, yr6, yi6, yr7, yi7;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_re, out_im;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;

  fft_out_serializer #(.N(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .y4(y4), .yr1(yr1), .yi1(yi1), .yr2(yr2), .yi2(yi2),
    .yr3(yr3), .yi3(yi3), .yr5(yr5), .yi5(yi5), .yr6(yr6), .yi6(yi6),
    .yr7(yr7), .yi7(yi7), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
    .out_last(out_last), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sc(input logic [15:0] v);
`ifdef FFT_SER_SCALE_EN
    return $signed(v) >>> 3;
`else
    return v;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  frame_t fq[$];
  int     midx = 0;
  bit     movf = 0;
  bit     started = 0;

  function automatic frame_t inputs_frame();
    frame_t f;
    f.re = {yr7, yr6, yr5, y4, yr3, yr2, yr1, y0};
    f.im = {yi7, yi6, yi5, 16'h0, yi3, yi2, yi1, 16'h0};
    return f;
  endfunction

  always @(posedge clk) begin
    int  sz;
    bit  cap;
    started = 1;
    if (rst) begin
      fq.delete();
      midx = 0;
      movf = 0;
    end else begin
      sz  = fq.size();
      cap = in_valid && (sz != 2);
      if (sz != 0 && out_ready) begin
        if (midx == 7) begin
          midx = 0;
          void'(fq.pop_front());
        end else begin
          midx++;
        end
      end
      if (cap) fq.push_back(inputs_frame());
      else if (in_valid) movf = 1;
    end
  end

  // ---------------- compare process ----------------
  bit          hold_pend = 0;
  logic [15:0] hold_re, hold_im;
  logic [2:0]  hold_idx;
  logic        hold_last;

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, fq.size() != 2});
      check("out_valid", {31'd0, out_valid}, {31'd0, fq.size() != 0});
      check("ovf", {31'd0, ovf}, {31'd0, movf});
      if (fq.size() != 0) begin
        check("out_re", {16'd0, out_re}, {16'd0, sc(fq[0].re[midx])});
        check("out_im", {16'd0, out_im}, {16'd0, sc(fq[0].im[midx])});
        check("out_idx", {29'd0, out_idx}, midx);
        check("out_last", {31'd0, out_last}, {31'd0, midx == 7});
      end else begin
        check("idle_idx", {29'd0, out_idx}, 32'd0);
      end
      if (hold_pend) begin
        check("hold_re", {16'd0, out_re}, {16'd0, hold_re});
        check("hold_im", {16'd0, out_im}, {16'd0, hold_im});
        check("hold_idx", {29'd0, out_idx}, {29'd0, hold_idx});
        check("hold_last", {31'd0, out_last}, {31'd0, hold_last});
      end
      hold_pend = out_valid && !out_ready && !rst;
      hold_re   = out_re;
      hold_im   = out_im;
      hold_idx  = out_idx;
      hold_last = out_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input frame_t f);
    y0 = f.re[0]; yr1 = f.re[1]; yr2 = f.re[2]; yr3 = f.re[3];
    y4 = f.re[4]; yr5 = f.re[5]; yr6 = f.re[6]; yr7 = f.re[7];
    yi1 = f.im[1]; yi2 = f.im[2]; yi3 = f.im[3];
    yi5 = f.im[5]; yi6 = f.im[6]; yi7 = f.im[7];
  endtask

  function automatic frame_t make_frame(input int seed);
    frame_t f;
    for (int k = 0; k < 8; k++) begin
      f.re[k] = 16'((seed * 257 + k * 4369 + 16'h8123) & 16'hFFFF);
      f.im[k] = (k == 0 || k == 4) ? 16'h0 : 16'((seed * 613 + k * 3855) ^ 16'h8000);
    end
    return f;
  endfunction

  // Hand-computed outputs for the test-plan frame.
  logic [15:0] lit_re [8];
  logic [15:0] lit_im [8];
  frame_t      t1;

  initial begin
    int seen, nv, first_v, last_v;
    bit found;
    bit [3:0] pat;

`ifdef FFT_SER_SCALE_EN
    lit_re = '{16'h0008, 16'h0002, 16'h0, 16'h0, 16'h0001, 16'h0, 16'h0, 16'h0};
    lit_im = '{16'h0000, 16'hFFFE, 16'h0, 16'h0, 16'h0000, 16'h0, 16'h0, 16'h0};
`else
    lit_re = '{16'h0040, 16'h0010, 16'h0, 16'h0, 16'h0008, 16'h0, 16'h0, 16'h0};
    lit_im = '{16'h0000, 16'hFFF0, 16'h0, 16'h0, 16'h0000, 16'h0, 16'h0, 16'h0};
`endif
    t1 = '0;
    t1.re[0] = 16'h0040;
    t1.re[1] = 16'h0010;
    t1.im[1] = 16'hFFF0;
    t1.re[4] = 16'h0008;

    rst = 1; in_valid = 0; out_ready = 0;
    drive('0);
    step(); step();

    // Reset values.
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_re", {16'd0, out_re}, 32'd0);
    check("rst_out_im", {16'd0, out_im}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    step();
    rst = 0;

    // Single frame, out_ready held high.
    drive(t1); in_valid = 1; out_ready = 1;
    step();
    in_valid = 0; drive('0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t1_valid", {31'd0, out_valid}, 32'd1);
      check("t1_re", {16'd0, out_re}, {16'd0, lit_re[k]});
      check("t1_im", {16'd0, out_im}, {16'd0, lit_im[k]});
      check("t1_idx", {29'd0, out_idx}, k);
      check("t1_last", {31'd0, out_last}, {31'd0, k == 7});
      step();
    end
    @(negedge clk);
    check("t1_valid_fall", {31'd0, out_valid}, 32'd0);
    step();

    // Same frame, out_ready toggling 1,0,0,1.
    drive(t1); in_valid = 1; out_ready = 0;
    step();
    in_valid = 0; drive('0);
    pat = 4'b1001;
    seen = 0;
    for (int c = 0; c < 64 && seen < 8; c++) begin
      out_ready = pat[c % 4];
      @(negedge clk);
      if (out_valid && out_ready) begin
        check("stall_order", {29'd0, out_idx}, seen);
        check("stall_re", {16'd0, out_re}, {16'd0, lit_re[seen]});
        seen++;
      end
      step();
    end
    check("stall_seen", seen, 32'd8);
    out_ready = 1;
    step();

    // Continuous frames every 8 cycles.
    nv = 0; first_v = -1; last_v = -1;
    for (int c = 0; c < 80; c++) begin
      in_valid = (c % 8 == 0) && (c < 64);
      if (in_valid) drive(make_frame(c / 8 + 1));
      @(negedge clk);
      if (out_valid) begin
        nv++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      step();
    end
    in_valid = 0;
    check("cont_count", nv, 32'd64);
    check("cont_span", last_v - first_v + 1, 32'd64);
    check("cont_ovf", {31'd0, ovf}, 32'd0);

    // Three frames offered with out_ready low: third is dropped.
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(make_frame(20 + i));
      in_valid = 1;
      @(negedge clk);
      if (i == 2) check("drop_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    in_valid = 0;
    @(negedge clk);
    check("drop_ovf", {31'd0, ovf}, 32'd1);
    out_ready = 1;
    repeat (18) step();
    @(negedge clk);
    check("drop_ovf_sticky", {31'd0, ovf}, 32'd1);
    check("drop_drained", {31'd0, out_valid}, 32'd0);

    // Reset mid-frame with the second buffer full.
    out_ready = 0;
    step();
    for (int i = 0; i < 2; i++) begin
      drive(make_frame(40 + i));
      in_valid = 1;
      step();
    end
    in_valid = 0;
    out_ready = 1;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_idx == 3'd3) begin
        found = 1;
        break;
      end
      step();
    end
    check("rst_mid_found_idx3", {31'd0, found}, 32'd1);
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_ovf", {31'd0, ovf}, 32'd0);
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("rst_mid_no_stale", nv, 32'd0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_out_serializer.md
# fft_out_serializer

Frame-to-stream converter on the output side of the 8-point radix-2 FFT datapath. It captures one complete parallel result frame from the last FFT stage (two real-only bins plus six complex bins, each 2**N bits wide). It then streams the frame out one complex sample per transfer, in natural bin order k = 0..7, over a valid/ready handshake. Two internal frame buffers (ping-pong) let the FFT deliver a new frame while the previous one is still draining.

## Interface
- N, 4, word width exponent; every data word is 2**N bits, two's complement.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a result frame is present on the y* inputs this cycle.
- in_ready  output  1  at least one frame buffer is free.
- y0, y4  input  2**N each  real-only bins 0 and 4.
- yr1, yi1, yr2, yi2, yr3, yi3  input  2**N each  real and imaginary parts of bins 1 to 3.
- yr5, yi5, yr6, yi6, yr7, yi7  input  2**N each  real and imaginary parts of bins 5 to 7.
- out_valid  output  1  a sample is presented.
- out_ready  input  1  the downstream block accepts the sample.
- out_re, out_im  output  2**N each  sample real and imaginary parts.
- out_idx  output  3  bin index k of the presented sample.
- out_last  output  1  high when out_idx == 7.
- ovf  output  1  sticky flag for a dropped frame.

## Operation
- Storage: two frame buffers, each holding 14 words. Bins 0 and 4 store real parts only; their imaginary part is output as 0.
- Status registers:
  - wp: 1-bit write pointer.
  - rp: 1-bit read pointer.
  - cnt: 0..2, number of full buffers.
  - idx: 3-bit read index.
- Capture: when in_valid && in_ready, all 14 words are written into buffer[wp] and wp toggles.
- in_ready = (cnt != 2).
- Drop: when in_valid && !in_ready, the frame is discarded, no state changes, and ovf is set. ovf is cleared only by rst.
- out_valid = (cnt != 0).
- out_re and out_im are muxed from buffer[rp] at idx.
- Transfer: occurs when out_valid && out_ready.
  - On a transfer, idx increments.
  - On a transfer with idx == 7, idx wraps to 0, rp toggles and the buffer is freed.
- cnt update: cnt increments on capture only and decrements on a final-sample transfer only. When both happen in the same cycle, cnt is unchanged.
- Stability: while out_valid && !out_ready, out_re, out_im, out_idx and out_last hold steady.
- Combinational paths: there is none from in_* or out_ready to any output. in_ready depends only on cnt.
- Effective state machine, from cnt:
  - EMPTY (cnt 0): moves to ONE on capture.
  - ONE (cnt 1): moves to TWO on capture without a final transfer; moves to EMPTY on a final transfer without capture; stays in ONE when both occur.
  - TWO (cnt 2): moves to ONE on a final transfer. Capture is impossible in TWO.

## Timing
- Reset values:
  - in_ready = 1; out_valid = 0; out_re = out_im = 0; out_idx = 0; out_last = 0; ovf = 0.
  - wp = rp = cnt = 0; all buffer words = 0.
- Latency: a frame captured at edge t presents bin 0 with out_valid = 1 in the cycle after t, provided cnt was 0 before t.
- Throughput: with out_ready held high, one sample per cycle and one frame every 8 cycles. The FFT may then deliver a frame every 8 cycles without any drop.
- Back-to-back frames: out_idx goes 7 to 0 with no bubble when the second buffer is full.
- rst asserted mid-frame: the current and buffered frames are discarded, and the reset values apply on the next cycle.

## Configuration
- FFT_SER_SCALE_EN:
  - Defined: out_re and out_im are the stored value arithmetically shifted right by 3 (divide by 8, rounding toward negative infinity, sign-extended). This normalises the 8-point FFT gain. out_im for bins 0 and 4 stays 0.
  - Undefined: samples pass through unmodified.

## Test plan
- Reset, then a single frame with y0=16'h0040, yr1=16'h0010, yi1=16'hFFF0, y4=16'h0008 and all other inputs 0, with out_ready=1:
  - out_valid rises one cycle after capture.
  - The output sequence is (0040,0000,k0), (0010,FFF0,k1), zeros for k2 to k3, (0008,0000,k4), zeros for k5 to k7.
  - out_last is high only at k7, and out_valid falls afterwards.
- Same frame with out_ready toggled 1,0,0,1 repeatedly: every bin appears exactly once, in order, and the data holds steady during stalls.
- out_ready=0 with three frames offered on consecutive cycles:
  - The first two are captured, in_ready drops after the second, and the third is dropped with ovf=1.
  - After out_ready=1, frames 1 then 2 drain intact and ovf stays 1.
- Continuous frames every 8 cycles with out_ready=1:
  - 64 contiguous samples are produced with no bubble and no ovf.
  - cnt returns to 0 and out_valid falls one cycle after the last.
- rst pulsed at out_idx=3 of a frame with the second buffer full: next cycle out_valid=0, in_ready=1, ovf=0, and no stale sample appears afterwards.
- With FFT_SER_SCALE_EN defined, y0=16'h0040 and yi1=16'hFFF0: outputs are 16'h0008 and 16'hFFFE.
